// File: rtl/scene_recovery_pkg.sv
// rtl/scene_recovery_pkg.sv - shared defaults, derived widths and clamp helpers for scene recovery
package scene_recovery_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int NCH_DEF    = 3;
  localparam int INT_W_DEF  = 2;
  localparam int FRAC_W_DEF = 10;
  localparam int CNT_W_DEF  = 16;

  function automatic int calc_diff_w(input int pix_w);
    return pix_w + 1;
  endfunction

  function automatic int calc_prod_w(input int pix_w, input int int_w, input int frac_w);
    return pix_w + int_w + frac_w + 2;
  endfunction

  // One bit wider than the rounded product so A + scaled can never wrap.
  function automatic int calc_sum_w(input int pix_w, input int int_w);
    return pix_w + int_w + 3;
  endfunction

  localparam int DIFF_W = calc_diff_w(PIX_W_DEF);
  localparam int PROD_W = calc_prod_w(PIX_W_DEF, INT_W_DEF, FRAC_W_DEF);
  localparam int SUM_W  = calc_sum_w(PIX_W_DEF, INT_W_DEF);

  function automatic logic [31:0] clamp_pix(input logic signed [31:0] v, input int pix_w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< pix_w) - 32'sd1;
    if (v < 0) clamp_pix = '0;
    else if (v > hi) clamp_pix = hi;
    else clamp_pix = v;
  endfunction

  function automatic logic is_clamped(input logic signed [31:0] v, input int pix_w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< pix_w) - 32'sd1;
    return (v < 0) || (v > hi);
  endfunction

endpackage

// File: rtl/srsc_channel_mac.sv
// rtl/srsc_channel_mac.sv - one colour channel: difference, multiply by 1/t, round, add A, clamp
module srsc_channel_mac
  import scene_recovery_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pix_i,
  input  logic [PIX_W-1:0]        atm_i,
  input  logic [INT_W+FRAC_W-1:0] inv_t_i,
  output logic [PIX_W-1:0]        pix_o,
  output logic                    clamp_o
);

  localparam int T_W    = INT_W + FRAC_W;
  localparam int DW     = calc_diff_w(PIX_W);
  localparam int PW     = calc_prod_w(PIX_W, INT_W, FRAC_W);
  localparam int SCL_W  = PW - FRAC_W;
  localparam int SW     = calc_sum_w(PIX_W, INT_W);
  localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC_W - 1));

  logic signed [DW-1:0]    diff_q, diff_d;
  logic [PIX_W-1:0]        atm1_q, atm2_q;
  logic [T_W-1:0]          inv_t_q;
  logic signed [PW-1:0]    prod_q, prod_d, rnd;
  logic signed [SCL_W-1:0] scaled;
  logic signed [SW-1:0]    sum;
  logic [PIX_W-1:0]        pix_q, pix_d;

  always_comb begin
    diff_d  = $signed({1'b0, pix_i}) - $signed({1'b0, atm_i});
    prod_d  = PW'(diff_q) * PW'($signed({1'b0, inv_t_q}));
    // Adding one half before the arithmetic shift rounds ties toward +inf.
    rnd     = prod_q + HALF;
    scaled  = SCL_W'(rnd >>> FRAC_W);
    sum     = SW'($signed({1'b0, atm2_q})) + SW'(scaled);
    pix_d   = PIX_W'(clamp_pix(32'(sum), PIX_W));
    clamp_o = is_clamped(32'(sum), PIX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      atm1_q  <= '0;
      inv_t_q <= '0;
      prod_q  <= '0;
      atm2_q  <= '0;
      pix_q   <= '0;
    end else if (en) begin
      diff_q  <= diff_d;
      atm1_q  <= atm_i;
      inv_t_q <= inv_t_i;
      prod_q  <= prod_d;
      atm2_q  <= atm1_q;
      pix_q   <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/scene_recovery_mul.sv
// rtl/scene_recovery_mul.sv - 3-stage dehaze radiance recovery with global stall and per-frame clamp count
module scene_recovery_mul
  import scene_recovery_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [NCH*PIX_W-1:0]    in_pix,
  input  logic [NCH*PIX_W-1:0]    in_atm,
  input  logic [INT_W+FRAC_W-1:0] in_inv_t,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic [NCH*PIX_W-1:0]    out_pix,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int NC_W = $clog2(NCH + 1);

  logic             en;
  logic             v1_q, v2_q, v3_q;
  logic             sof1_q, sof2_q, sof3_q;
  logic [NCH-1:0]   clamp;
  logic [NC_W-1:0]  nclamp_d, nclamp_q;
  logic [CNT_W-1:0] sat_q, sat_d;
  logic [CNT_W:0]   acc;

  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    srsc_channel_mac #(
      .PIX_W  (PIX_W),
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .pix_i   (in_pix[k*PIX_W +: PIX_W]),
      .atm_i   (in_atm[k*PIX_W +: PIX_W]),
      .inv_t_i (in_inv_t),
      .pix_o   (out_pix[k*PIX_W +: PIX_W]),
      .clamp_o (clamp[k])
    );
  end

  always_comb begin
    nclamp_d = '0;
    for (int k = 0; k < NCH; k++) nclamp_d = nclamp_d + NC_W'(clamp[k]);
  end

  // Count follows the delivered beat: an sof beat restarts the frame total.
  always_comb begin
    acc   = (CNT_W + 1)'(sat_q) + (CNT_W + 1)'(nclamp_q);
    sat_d = sat_q;
    if (v3_q && out_ready) begin
      if (sof3_q) sat_d = CNT_W'(nclamp_q);
      else if (acc[CNT_W]) sat_d = '1;
      else sat_d = acc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sof1_q   <= 1'b0;
      sof2_q   <= 1'b0;
      sof3_q   <= 1'b0;
      nclamp_q <= '0;
      sat_q    <= '0;
    end else begin
      sat_q <= sat_d;
      if (en) begin
        v1_q     <= in_valid;
        sof1_q   <= in_valid && in_sof;
        v2_q     <= v1_q;
        sof2_q   <= sof1_q;
        v3_q     <= v2_q;
        sof3_q   <= sof2_q;
        nclamp_q <= nclamp_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_sof   = sof3_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_scene_recovery_mul.sv
// tb/tb_scene_recovery_mul.sv - self-checking bench for scene_recovery_mul
module tb_scene_recovery_mul;

  logic        clk;
  logic        rst, in_valid, in_ready, in_sof, out_valid, out_ready, out_sof;
  logic [23:0] in_pix, in_atm, out_pix;
  logic [11:0] in_inv_t;
  logic [15:0] sat_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  scene_recovery_mul #(
    .PIX_W (8), .NCH (3), .INT_W (2), .FRAC_W (10), .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .in_atm    (in_atm),
    .in_inv_t  (in_inv_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_pix   (out_pix),
    .sat_count (sat_count)
  );

  typedef struct {
    logic [23:0] j;
    logic        sof;
    int          nc;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] atm;
    logic [11:0] t;
    logic        sof;
    logic [23:0] j;
    int          nc;
    int          sat_after;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[8];
  int          tests, fails, cyc, model_sat, acc_count, del_count;
  bit          lat_mode, use_tbl, hold_pending, sat_pending;
  logic [23:0] hold_pix, tbl_j;
  logic        hold_sof;
  int          tbl_nc;

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  // Reference: real-valued scale, floor(x + 0.5) rounding, integer clamp.
  function automatic void model(input logic [23:0] pix, input logic [23:0] atm,
                                input logic [11:0] t, output logic [23:0] j, output int nc);
    nc = 0;
    j  = '0;
    for (int k = 0; k < 3; k++) begin
      int  i, a, v;
      real s;
      i = int'(pix[k*8 +: 8]);
      a = int'(atm[k*8 +: 8]);
      s = $floor(real'((i - a) * int'(t)) / 1024.0 + 0.5);
      v = a + $rtoi(s);
      if (v < 0) begin v = 0; nc++; end
      else if (v > 255) begin v = 255; nc++; end
      j[k*8 +: 8] = 8'(v);
    end
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic [23:0] mj;
    int          mnc;
    #1;
    if (!rst) begin
      if (hold_pending)
        check(out_valid === 1'b1 && out_pix === hold_pix && out_sof === hold_sof, "stall_hold",
              {out_valid, out_sof, out_pix}, {1'b1, hold_sof, hold_pix});
      if (sat_pending)
        check(sat_count === 16'(model_sat), "sat_count", sat_count, model_sat);
      hold_pending = 0;
      sat_pending  = 0;
      if (out_valid === 1'b1 && out_ready) begin
        check(q.size() > 0, "spurious_delivery", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          del_count++;
          check(out_pix === e.j && out_sof === e.sof, "out_beat", {out_sof, out_pix}, {e.sof, e.j});
          if (e.lat) check(cyc == e.acc_cyc + 3, "latency", cyc - e.acc_cyc, 3);
          if (e.sof) model_sat = e.nc;
          else model_sat = (model_sat + e.nc > 65535) ? 65535 : model_sat + e.nc;
          sat_pending = 1;
        end
      end else if (out_valid === 1'b1) begin
        hold_pending = 1;
        hold_pix     = out_pix;
        hold_sof     = out_sof;
      end
      if (in_valid && in_ready === 1'b1) begin
        if (use_tbl) begin mj = tbl_j; mnc = tbl_nc; end
        else model(in_pix, in_atm, in_inv_t, mj, mnc);
        e.j = mj; e.nc = mnc; e.sof = in_sof; e.acc_cyc = cyc; e.lat = lat_mode;
        q.push_back(e);
        acc_count++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    q.delete();
    model_sat    = 0;
    hold_pending = 0;
    sat_pending  = 0;
    check(out_valid === 1'b0, {tag, "_out_valid"}, out_valid, 0);
    check(out_sof === 1'b0, {tag, "_out_sof"}, out_sof, 0);
    check(out_pix === 24'h0, {tag, "_out_pix"}, out_pix, 0);
    check(sat_count === 16'h0, {tag, "_sat_count"}, sat_count, 0);
    check(in_ready === 1'b1, {tag, "_in_ready"}, in_ready, 1);
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 50 && q.size() > 0; g++) tick();
    check(q.size() == 0, "drain_timeout", q.size(), 0);
    tick();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; model_sat = 0; acc_count = 0; del_count = 0;
    lat_mode = 0; use_tbl = 0; hold_pending = 0; sat_pending = 0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; in_atm = '0; in_inv_t = '0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_and_check("reset");

    vecs[0] = '{pk(10,128,250), pk(200,200,200), 12'd1024, 1'b1, pk(10,128,250), 0, 0};
    vecs[1] = '{pk(200,50,100), pk(100,200,100), 12'd2048, 1'b0, pk(255,0,100),  2, 2};
    vecs[2] = '{pk(50,0,255),   pk(200,0,255),   12'd3072, 1'b0, pk(0,0,255),    1, 3};
    vecs[3] = '{pk(101,99,103), pk(100,100,100), 12'd512,  1'b0, pk(101,100,102), 0, 3};
    vecs[4] = '{pk(0,77,255),   pk(12,34,56),    12'd0,    1'b0, pk(12,34,56),   0, 3};
    vecs[5] = '{pk(255,0,0),    pk(0,255,0),     12'd4095, 1'b0, pk(255,0,0),    2, 5};
    vecs[6] = '{pk(0,255,17),   pk(255,0,99),    12'd1024, 1'b0, pk(0,255,17),   0, 5};
    vecs[7] = '{pk(200,100,100), pk(100,100,100), 12'd2048, 1'b1, pk(255,100,100), 1, 1};

    lat_mode = 1;
    use_tbl  = 1;
    for (int i = 0; i < 8; i++) begin
      in_pix = vecs[i].pix; in_atm = vecs[i].atm; in_inv_t = vecs[i].t; in_sof = vecs[i].sof;
      tbl_j = vecs[i].j; tbl_nc = vecs[i].nc;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check(sat_count === 16'(vecs[i].sat_after), "tbl_sat_count", sat_count, vecs[i].sat_after);
    end
    use_tbl = 0;
    drain();

    lat_mode  = 0;
    acc_count = 0;
    del_count = 0;
    for (int g = 0; g < 1000 && acc_count < 20; g++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sof    = (acc_count == 0);
      in_pix    = 24'($urandom);
      in_atm    = 24'($urandom);
      in_inv_t  = 12'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    check(acc_count == 20, "rand_accepted", acc_count, 20);
    check(del_count == 20, "rand_delivered", del_count, 20);

    lat_mode = 1;
    in_pix   = 24'hFFFFFF;
    in_atm   = 24'h000000;
    in_inv_t = 12'hFFF;
    for (int n = 0; n < 23334; n++) begin
      in_valid = 1'b1;
      in_sof   = (n == 0);
      tick();
    end
    drain();
    check(sat_count === 16'hFFFF, "sat_ceiling", sat_count, 16'hFFFF);

    lat_mode  = 0;
    del_count = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_sof   = (n == 0);
      in_pix   = 24'($urandom);
      in_atm   = 24'($urandom);
      in_inv_t = 12'($urandom);
      tick();
    end
    reset_and_check("inflight_reset");
    repeat (8) tick();
    check(del_count == 0, "post_reset_delivered", del_count, 0);
    check(sat_count === 16'h0, "post_reset_sat", sat_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scene_recovery_mul.md
SCENE_RECOVERY_MUL -- requirements
Module: scene_recovery_mul

Interface
REQ-001 Parameter PIX_W, default 8, pixel/atmospheric-light channel width, unsigned.
REQ-002 Parameter NCH, default 3, number of colour channels processed per beat.
REQ-003 Parameter INT_W, default 2, integer bits of inverse transmission.
REQ-004 Parameter FRAC_W, default 10, fraction bits of inverse transmission.
REQ-005 Parameter CNT_W, default 16, saturation counter width.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block accepts beat this cycle.
REQ-010 in_sof  input  1  beat is first pixel of frame.
REQ-011 in_pix  input  NCH*PIX_W  hazy pixel I_c; channel k at bits [k*PIX_W +: PIX_W].
REQ-012 in_atm  input  NCH*PIX_W  atmospheric light A_c, same packing.
REQ-013 in_inv_t  input  INT_W+FRAC_W  1/t, unsigned Q(INT_W).(FRAC_W), shared by all channels.
REQ-014 out_valid  output  1  output beat valid.
REQ-015 out_ready  input  1  downstream accepts beat.
REQ-016 out_sof  output  1  in_sof delayed with its beat.
REQ-017 out_pix  output  NCH*PIX_W  recovered radiance J_c, same packing.
REQ-018 sat_count  output  CNT_W  channels clamped in current frame.

Function
REQ-019 Per channel: J = clamp(A + round((I - A) * inv_t / 2^FRAC_W), 0, 2^PIX_W-1).
REQ-020 Difference I - A computed signed, PIX_W+1 bits; product signed, full width PIX_W+INT_W+FRAC_W+2 bits, no truncation before rounding.
REQ-021 Rounding: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W (round half toward +inf).
REQ-022 Sum A + scaled computed with at least 2 guard bits; negative -> 0, above 2^PIX_W-1 -> 2^PIX_W-1.
REQ-023 Pipeline of 3 register stages: S1 register inputs and difference; S2 multiply; S3 round, add, clamp, output register.
REQ-024 Latency: accepted beat appears on out_* exactly 3 cycles after acceptance when out_ready held high.
REQ-025 Global stall: en = !out_valid | out_ready; all stages advance only when en; in_ready = en.
REQ-026 Beat accepted iff in_valid & in_ready; beat delivered iff out_valid & out_ready.
REQ-027 While out_valid & !out_ready, out_pix, out_sof, out_valid are held stable.
REQ-028 Bubbles (in_valid low) propagate as invalid stages; throughput 1 beat/cycle with no backpressure.
REQ-029 inv_t = 0 yields J = A; inv_t = 2^FRAC_W (1.0) yields J = I exactly.
REQ-030 sat_count: on delivery of beat with out_sof=1, loads number of clamped channels of that beat; on other deliveries, adds clamped-channel count; saturates at 2^CNT_W-1; unchanged when no delivery.
REQ-031 Per-beat clamped-channel count carried through S3 alongside data, width $clog2(NCH+1).

Reset
REQ-032 rst clears all stage valid bits, out_valid=0, out_sof=0, out_pix=0, sat_count=0 next edge.
REQ-033 rst mid-operation discards all in-flight beats; none delivered after reset deasserts.
REQ-034 in_ready=1 during and after reset (en true since out_valid=0).

Structure
REQ-035 Package scene_recovery_pkg holds default parameters, derived widths (DIFF_W, PROD_W, SUM_W) and clamp function.
REQ-036 Sub-module srsc_channel_mac implements one channel's S1-S3 datapath with en input; instantiated NCH times via generate.
REQ-037 Handshake, valid/sof pipeline and sat_count reside in scene_recovery_mul top.

Verification (PIX_W=8, FRAC_W=10, NCH=3)
REQ-038 I=(10,128,250), A=(200,200,200), inv_t=1024, out_ready=1 -> J=(10,128,250) 3 cycles later, sat_count=0.
REQ-039 I=200, A=100, inv_t=2048 -> 255; I=50, A=200, inv_t=3072 -> 0; both counted in sat_count.
REQ-040 Rounding: I=101,A=100,inv_t=512 -> 101; I=99,A=100,inv_t=512 -> 100; inv_t=0 -> J=A.
REQ-041 Stream 20 beats, out_ready random 50% -> all 20 delivered in order, held stable under stall, no loss/dup.
REQ-042 Frame with 5 saturating channels then sof beat with 1 -> sat_count 5 then 1; forced 70000 clamps -> 65535.
REQ-043 rst asserted with 3 beats in flight -> out_valid=0 next cycle, none delivered, sat_count=0.
